// File: rtl/nv_latch_fifo_pkg.sv
// Shared types and helpers for the latch-array FIFO write controller.
// Holds the write FSM encoding, address-width derivation and pointer wrap.
package nv_latch_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2
  } wr_state_e;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FIFO_WIDTH_DEF = 32;
  localparam int PTR_W          = 16;

  function automatic int fifo_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Wrap is explicit so the helper also behaves for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                               input int depth);
    if (ptr == PTR_W'(depth - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/nv_latch_fifo_en_gen.sv
// One-hot latch enable generator: registers a decode of wr_ptr during ARM.
// The enable is high for exactly the CAPT cycle and falls on the commit edge.
module nv_latch_fifo_en_gen
  import nv_latch_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = fifo_aw(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             arm,
  input  logic [AW-1:0]    wr_ptr,
  output logic [DEPTH-1:0] lat_en
);

  logic [DEPTH-1:0] en_dec;

  always_comb begin
    en_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (arm && (wr_ptr == AW'(i))) begin
        en_dec[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      lat_en <= '0;
    end else begin
      lat_en <= en_dec;
    end
  end

endmodule

// File: rtl/nv_latch_fifo_wr_ctrl.sv
// Write/read controller for a negative-edge latch-array FIFO.
// Each push takes IDLE -> ARM -> CAPT so latch data is stable around the enable pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a push; lat_d loaded on accept
// ARM   | lat_d stable; enable for wr_ptr registered at end of cycle
// CAPT  | enable high; it falls on the next edge, entry committed then
module nv_latch_fifo_wr_ctrl
  import nv_latch_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int AW    = fifo_aw(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic [DEPTH-1:0] lat_en,
  output logic [WIDTH-1:0] lat_d,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_mux_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW:0]      count
);

  localparam logic [AW+1:0] DEPTH_OCC = DEPTH[AW+1:0];

  wr_state_e       state;
  wr_state_e       state_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count_nxt;
  logic [AW+1:0]   occ;
  logic            in_flight;
  logic            full_pending;
  logic            accept;
  logic            arm;
  logic            commit;
  logic            pop;

  // Full check uses registered count only, so a pop frees space one cycle later.
  assign in_flight    = (state != IDLE);
  assign occ          = {1'b0, count} + {{(AW+1){1'b0}}, in_flight};
  assign full_pending = (occ == DEPTH_OCC);

  assign rd_pvld = (count != '0);
  assign pop     = rd_pvld && rd_prdy;
  assign rd_pd   = rd_mux_pd;

  always_comb begin
    state_nxt = state;
    wr_prdy   = 1'b0;
    accept    = 1'b0;
    arm       = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        wr_prdy = !full_pending && !nvdla_core_rst;
        accept  = wr_pvld && wr_prdy;
        if (accept) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        arm       = 1'b1;
        state_nxt = CAPT;
      end
      CAPT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({commit, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      lat_d   <= '0;
      wr_ptr  <= '0;
      rd_addr <= '0;
      count   <= '0;
    end else begin
      if (accept) begin
        lat_d <= wr_pd;
      end
      if (commit) begin
        wr_ptr <= AW'(ptr_inc(PTR_W'(wr_ptr), DEPTH));
      end
      if (pop) begin
        rd_addr <= AW'(ptr_inc(PTR_W'(rd_addr), DEPTH));
      end
      count <= count_nxt;
    end
  end

  nv_latch_fifo_en_gen #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_en_gen (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .arm            (arm),
    .wr_ptr         (wr_ptr),
    .lat_en         (lat_en)
  );

endmodule

// File: tb/tb_nv_latch_fifo_wr_ctrl.sv
// Directed and random bench for nv_latch_fifo_wr_ctrl with a behavioural latch array.
module tb_nv_latch_fifo_wr_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int AW    = 3;

  logic             nvdla_core_clk;
  logic             nvdla_core_rst;
  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic [DEPTH-1:0] lat_en;
  logic [WIDTH-1:0] lat_d;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_mux_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [WIDTH-1:0] rd_pd;
  logic [AW:0]      count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] refq[$];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] en_prev = '0;

  nv_latch_fifo_wr_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .lat_en         (lat_en),
    .lat_d          (lat_d),
    .rd_addr        (rd_addr),
    .rd_mux_pd      (rd_mux_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .count          (count)
  );

  initial begin
    nvdla_core_clk = 1'b0;
    forever #5 nvdla_core_clk = ~nvdla_core_clk;
  end

  // Latch cells capture lat_d when their enable falls.
  always @(lat_en) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (en_prev[i] && !lat_en[i]) mem[i] = lat_d;
    end
    en_prev = lat_en;
  end

  assign rd_mux_pd = mem[rd_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    nvdla_core_rst = 1'b1;
    tick();
    tick();
    nvdla_core_rst = 1'b0;
    #1;
    refq.delete();
  endtask

  task automatic push_one(input logic [WIDTH-1:0] d);
    wr_pd   = d;
    wr_pvld = 1'b1;
    for (int w = 0; w < 20 && !wr_prdy; w++) tick();
    chk("push_rdy", wr_prdy, 1);
    refq.push_back(d);
    tick();
    wr_pvld = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [WIDTH-1:0] exp_d;
    logic [DEPTH-1:0] prev_en;
    logic [WIDTH-1:0] prev_d;
    int mcnt;
    int cdown;
    bit acc;
    bit pp;
    int wr_bias;
    int rd_bias;

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    nvdla_core_rst = 1'b1;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    wr_pd   = '0;

    // Reset state
    tick();
    tick();
    chk("rst_lat_en", lat_en, 0);
    chk("rst_lat_d", lat_d, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_pvld", rd_pvld, 0);
    chk("rst_wr_prdy", wr_prdy, 0);
    nvdla_core_rst = 1'b0;
    #1;

    // Single push: edge 1 accept, edge 2 enable rises, edge 3 enable falls and commit
    wr_pd   = 32'hA5A5_0001;
    wr_pvld = 1'b1;
    chk("single_prdy", wr_prdy, 1);
    tick();
    wr_pvld = 1'b0;
    chk("single_lat_d_e1", lat_d, 32'hA5A5_0001);
    chk("single_lat_en_e1", lat_en, 0);
    chk("single_prdy_arm", wr_prdy, 0);
    tick();
    chk("single_lat_en_e2", lat_en, 1);
    chk("single_count_e2", count, 0);
    chk("single_prdy_capt", wr_prdy, 0);
    tick();
    chk("single_lat_en_e3", lat_en, 0);
    chk("single_count_e3", count, 1);
    chk("single_rd_pvld_e3", rd_pvld, 1);
    chk("single_rd_pd", rd_pd, 32'hA5A5_0001);
    rd_prdy = 1'b1;
    tick();
    rd_prdy = 1'b0;
    chk("single_count_pop", count, 0);
    chk("single_rd_addr_pop", rd_addr, 1);
    chk("single_rd_pvld_pop", rd_pvld, 0);

    // Back-to-back pushes until full, no pops
    do_reset();
    wr_pvld = 1'b1;
    for (int k = 0; k < 27; k++) begin
      wr_pd = 32'hD000_0000 + 32'(k / 3);
      chk("fill_prdy", wr_prdy, ((k % 3 == 0) && (k < 24)) ? 1 : 0);
      chk("fill_lat_en", lat_en, ((k % 3 == 2) && (k < 24)) ? (64'd1 << (k / 3)) : 0);
      chk("fill_count", count, (k < 24) ? 64'(k / 3) : 8);
      if ((k % 3 == 1) && (k < 24)) chk("fill_lat_d", lat_d, 32'hD000_0000 + 32'(k / 3));
      if ((k % 3 == 0) && (k < 24)) refq.push_back(wr_pd);
      tick();
    end

    // Full with 9th push pending; one pop frees a slot a cycle later
    wr_pd = 32'hE000_0009;
    chk("full_prdy", wr_prdy, 0);
    exp_d = refq.pop_front();
    chk("full_rd_pd", rd_pd, exp_d);
    rd_prdy = 1'b1;
    tick();
    rd_prdy = 1'b0;
    chk("full_count_pop", count, 7);
    chk("full_prdy_after_pop", wr_prdy, 1);
    refq.push_back(wr_pd);
    tick();
    wr_pvld = 1'b0;
    chk("full_prdy_arm", wr_prdy, 0);
    tick();
    chk("wrap_lat_en", lat_en, 1);
    chk("wrap_count_capt", count, 7);
    tick();
    chk("wrap_lat_en_fall", lat_en, 0);
    chk("wrap_count", count, 8);
    chk("wrap_prdy", wr_prdy, 0);
    chk("wrap_rd_pd", rd_pd, 32'hD000_0001);

    // Commit and pop in the same cycle with count=3
    do_reset();
    push_one(32'hC000_0000);
    push_one(32'hC000_0001);
    push_one(32'hC000_0002);
    chk("cp_count_pre", count, 3);
    wr_pd   = 32'hC000_0003;
    wr_pvld = 1'b1;
    chk("cp_prdy", wr_prdy, 1);
    refq.push_back(wr_pd);
    tick();
    wr_pvld = 1'b0;
    tick();
    chk("cp_lat_en_capt", lat_en, 64'h08);
    exp_d = refq.pop_front();
    chk("cp_rd_pd", rd_pd, exp_d);
    rd_prdy = 1'b1;
    tick();
    rd_prdy = 1'b0;
    chk("cp_count", count, 3);
    chk("cp_rd_addr", rd_addr, 1);
    wr_pd   = 32'hC000_0004;
    wr_pvld = 1'b1;
    refq.push_back(wr_pd);
    tick();
    wr_pvld = 1'b0;
    tick();
    chk("cp_wr_ptr_adv", lat_en, 64'h10);
    tick();
    chk("cp_count_next", count, 4);
    chk("cp_rd_pd_next", rd_pd, 32'hC000_0001);

    // Reset asserted while in ARM
    wr_pd   = 32'hBAD0_BAD0;
    wr_pvld = 1'b1;
    tick();
    wr_pvld = 1'b0;
    nvdla_core_rst = 1'b1;
    tick();
    chk("rarm_lat_en", lat_en, 0);
    chk("rarm_count", count, 0);
    chk("rarm_rd_addr", rd_addr, 0);
    chk("rarm_rd_pvld", rd_pvld, 0);
    chk("rarm_wr_prdy", wr_prdy, 0);
    nvdla_core_rst = 1'b0;
    refq.delete();
    tick();
    chk("rarm_lat_en_hold", lat_en, 0);
    chk("rarm_prdy_after", wr_prdy, 1);
    wr_pd   = 32'hF000_0000;
    wr_pvld = 1'b1;
    tick();
    wr_pvld = 1'b0;
    tick();
    chk("rarm_wr_ptr0", lat_en, 1);
    tick();
    chk("rarm_count_after", count, 1);
    chk("rarm_rd_pd", rd_pd, 32'hF000_0000);

    // Random push/pop with running invariant and data-order checks
    do_reset();
    mcnt    = 0;
    cdown   = 0;
    prev_en = lat_en;
    prev_d  = lat_d;
    wr_bias = 3;
    rd_bias = 3;
    for (int i = 0; i < 10000; i++) begin
      if (i % 1000 == 0) begin
        wr_bias = $urandom_range(1, 4);
        rd_bias = $urandom_range(1, 4);
      end
      chk("rnd_onehot", ((lat_en & (lat_en - 1'b1)) == '0) ? 1 : 0, 1);
      if ((prev_en & ~lat_en) != '0) chk("rnd_lat_d_hold", lat_d, prev_d);
      chk("rnd_count", count, 64'(mcnt));
      prev_en = lat_en;
      prev_d  = lat_d;

      wr_pvld = ($urandom_range(0, 4) < wr_bias);
      rd_prdy = ($urandom_range(0, 4) < rd_bias);
      wr_pd   = $urandom();
      acc = wr_pvld && wr_prdy;
      pp  = rd_pvld && rd_prdy;
      if (pp) begin
        if (refq.size() == 0) begin
          chk("rnd_pop_empty_ref", rd_pvld, 0);
        end else begin
          exp_d = refq.pop_front();
          chk("rnd_rd_pd", rd_pd, exp_d);
        end
      end
      if (acc) refq.push_back(wr_pd);

      if (cdown > 0) begin
        cdown--;
        if (cdown == 0) mcnt++;
      end
      if (acc) cdown = 2;
      if (pp) mcnt--;
      tick();
    end
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
